uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART transmitter between NUM_REQ byte sources using round-robin arbitration with optional
//  packet lock. Sequences each frame: captures the byte, pulses tx_start, waits for tx_done.
//  Owns the baud_sel configuration driven to the baud generator; changes are applied only between frames.
//  Sits between client logic (valid/ready byte streams) and the baud_generator/transmitter pair.
// PARAMETERS
//  NUM_REQ      4       number of requesters (2..8)
//  TIMEOUT_CYC  400000  max clk cycles in WAIT before abort; exceeds one 11-bit frame at slowest rate (11*31251)
//  CNT_W        20      width of timeout counter; must hold TIMEOUT_CYC
// PORTS
//  clk          in   1          system clock
//  reset        in   1          asynchronous, active-high reset
//  req_valid    in   NUM_REQ    per-requester byte valid; held until its req_ready
//  req_data     in   8*NUM_REQ  per-requester byte; requester i uses [8*i+7:8*i]
//  req_last     in   NUM_REQ    1 = byte ends packet (releases lock); 0 = keep grant
//  req_ready    out  NUM_REQ    one-cycle accept strobe, at most one bit high
//  tx_start     out  1          one-cycle pulse: transmitter loads tx_data
//  tx_data      out  8          byte for current frame; stable from tx_start until tx_done
//  tx_done      in   1          one-cycle pulse from transmitter at end of stop bit
//  cfg_wr       in   1          write strobe for cfg_baud_sel
//  cfg_baud_sel in   2          requested rate code
//  baud_sel     out  2          rate code to baud generator
//  grant_id     out  $clog2(NUM_REQ)  index of current/last granted requester
//  busy         out  1          high in any state other than IDLE
//  timeout_err  out  1          sticky; set on timeout abort, cleared by err_clr
//  err_clr      in   1          clears timeout_err
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, req_ready=0, tx_start=0, tx_data=0, baud_sel=2'b00, grant_id=0,
//   rr pointer=0, lock=0, pending cfg cleared, timeout_err=0, busy=0. Reset mid-frame abandons the frame.
//  FSM: IDLE -> LOAD -> START -> WAIT -> (LOAD | IDLE).
//  IDLE: if |req_valid, register winner = first set bit searching upward from rr pointer (wrapping); -> LOAD.
//  LOAD: req_ready[grant_id]=1 for exactly this cycle; tx_data<=req_data[grant]; lock<=~req_last[grant]; -> START.
//  START: tx_start=1 for one cycle; timeout counter cleared; -> WAIT.
//  WAIT: tx_done ignored in START cycle, counted only in WAIT. On tx_done:
//   - lock=1 and req_valid[grant_id]=1 -> LOAD (same requester, no re-arbitration).
//   - otherwise lock<=0, rr pointer<=grant_id+1 (mod NUM_REQ), -> IDLE.
//   Counter reaches TIMEOUT_CYC-1 without tx_done -> timeout_err<=1, lock<=0, pointer advanced, -> IDLE.
//  Latency: req_valid seen in IDLE at edge N -> req_ready at cycle N+1 -> tx_start at N+2.
//   Locked back-to-back bytes: tx_done at cycle M -> req_ready M+1 -> tx_start M+2.
//  Config: cfg_wr while IDLE -> baud_sel updates on that edge. cfg_wr while busy -> value held pending
//   (later writes overwrite), applied on first IDLE cycle. Never changes between START and tx_done.
//  Simultaneous: cfg_wr in IDLE with req_valid -> baud_sel and grant both register on the same edge.
//   err_clr with a timeout on the same edge -> set wins.
//  Requester dropping req_valid during LOAD is a protocol violation; no recovery beyond timeout.
// STRUCTURE
//  Shared package uart_pkg: state encoding (IDLE/LOAD/START/WAIT), baud code constants
//   (00=slowest .. 11=fastest), byte width 8, frame length 11.
//  One sub-module: uart_rr_pick (combinational round-robin pick: req vector + pointer -> index, any).
//  Timeout counter, FSM, config register stay in this module.
// TESTING
//  T1 single: req_valid=4'b0100, data 8'hA5, last=1 -> ready[2] 1 cycle, tx_start next, tx_data=A5, grant_id=2.
//  T2 round-robin: all 4 valid, last=1, tx_done 20 cycles after each start -> grant order 0,1,2,3,0.
//  T3 lock: req0 sends 3 bytes last=0,0,1 while req1 valid -> req0 served 3x consecutively, then req1.
//  T4 config: cfg_wr=11 during WAIT -> baud_sel unchanged until tx_done, then 11 in IDLE; cfg_wr in IDLE -> next edge.
//  T5 timeout: TIMEOUT_CYC=64, never pulse tx_done -> timeout_err=1 at cycle 64 of WAIT, IDLE, next requester served.
//  T6 reset mid-WAIT: assert reset -> busy, tx_start, req_ready, lock 0 at once; after release T1 passes unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, baud codes and frame constants for the UART transmit path
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;
  localparam logic [1:0] BAUD_SLOWEST = 2'b00;
  localparam logic [1:0] BAUD_SLOW = 2'b01;
  localparam logic [1:0] BAUD_FAST = 2'b10;
  localparam logic [1:0] BAUD_FASTEST = 2'b11;
  localparam int BYTE_W = 8;
  localparam int FRAME_LEN = 11;
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester, transmitter and config signals of the transmit scheduler
interface uart_tx_scheduler_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic tx_start;
  logic [BYTE_W-1:0] tx_data;
  logic tx_done;
  logic cfg_wr;
  logic [1:0] cfg_baud_sel;
  logic [1:0] baud_sel;
  logic [IW-1:0] grant_id;
  logic busy;
  logic timeout_err;
  logic err_clr;
  modport slave (
    input req_valid, req_data, req_last, tx_done, cfg_wr, cfg_baud_sel, err_clr,
    output req_ready, tx_start, tx_data, baud_sel, grant_id, busy, timeout_err
  );
  modport master (
    output req_valid, req_data, req_last, tx_done, cfg_wr, cfg_baud_sel, err_clr,
    input req_ready, tx_start, tx_data, baud_sel, grant_id, busy, timeout_err
  );
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin pick of the first request at or above the pointer, wrapping
module uart_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] k;
  // scan offsets downward so the smallest offset from ptr is the last, winning assignment
  always_comb begin
    idx = '0;
    k = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) idx = k;
    end
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between requesters with packet lock and deferred baud config
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT_CYC = 400000,
  parameter int CNT_W = 20
) (
  input logic clk,
  input logic reset,
  uart_tx_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state, state_nx;
  logic [IW-1:0] ptr, pick_idx, nxt_ptr;
  logic pick_any, lock, pend_v, tmo, tmo_hit, reload, frame_end;
  logic [1:0] pend;
  logic [CNT_W-1:0] cnt;
  uart_rr_pick #(.N(NUM_REQ)) u_pick (.req(bus.req_valid), .ptr(ptr), .idx(pick_idx), .any(pick_any));
  assign tmo = cnt == CNT_W'(TIMEOUT_CYC - 1);
  assign reload = bus.tx_done && lock && bus.req_valid[bus.grant_id];
  assign frame_end = state == WAIT && (bus.tx_done || tmo);
  assign tmo_hit = state == WAIT && !bus.tx_done && tmo;
  assign nxt_ptr = (bus.grant_id == IW'(NUM_REQ - 1)) ? '0 : bus.grant_id + IW'(1);
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  // next state and per-state strobes
  always_comb begin
    state_nx = state;
    bus.busy = state != IDLE;
    bus.tx_start = state == START;
    bus.req_ready = (state == LOAD) ? NUM_REQ'(1) << bus.grant_id : '0;
    case (state)
      IDLE: state_nx = pick_any ? LOAD : IDLE;
      LOAD: state_nx = START;
      START: state_nx = WAIT;
      WAIT: state_nx = bus.tx_done ? (reload ? LOAD : IDLE) : (tmo ? IDLE : WAIT);
      default: state_nx = IDLE;
    endcase
  end
  // grant, frame byte, packet lock and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.grant_id <= '0;
      bus.tx_data <= '0;
      lock <= 1'b0;
      ptr <= '0;
    end else begin
      if (state == IDLE && pick_any) bus.grant_id <= pick_idx;
      if (state == LOAD) begin
        bus.tx_data <= bus.req_data[{bus.grant_id, 3'b000} +: BYTE_W];
        lock <= ~bus.req_last[bus.grant_id];
      end
      if (frame_end && !reload) begin
        lock <= 1'b0;
        ptr <= nxt_ptr;
      end
    end
  end
  // frame timeout counter, runs only while waiting for tx_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else cnt <= (state == WAIT) ? cnt + CNT_W'(1) : '0;
  end
  // sticky timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.timeout_err <= 1'b0;
    else bus.timeout_err <= tmo_hit | (bus.timeout_err & ~bus.err_clr);
  end
  // baud code only moves while idle; writes during a frame wait in pend
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.baud_sel <= BAUD_SLOWEST;
      pend <= BAUD_SLOWEST;
      pend_v <= 1'b0;
    end else if (state == IDLE) begin
      bus.baud_sel <= bus.cfg_wr ? bus.cfg_baud_sel : (pend_v ? pend : bus.baud_sel);
      pend_v <= 1'b0;
    end else if (bus.cfg_wr) begin
      pend <= bus.cfg_baud_sel;
      pend_v <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench with requester queues, a transmitter model and a frame monitor
module tb_uart_tx_scheduler;
  import uart_pkg::*;
  localparam int NR = 4;
  localparam int TMO = 64;
  localparam int IW = $clog2(NR);
  logic clk = 1'b0;
  logic reset = 1'b1;
  uart_tx_scheduler_if #(.NUM_REQ(NR)) bus ();
  uart_tx_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO), .CNT_W(20)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [8:0] src_q[NR][$];
  logic [IW+7:0] sb_q[$];
  logic [IW+7:0] obs_q[$];
  logic [NR-1:0] took;
  int checks = 0;
  int failures = 0;
  int auto_done = 1;
  int done_delay = 20;
  int cd = 0;
  // requester model: present queue head, retire it the cycle after its ready strobe
  initial begin
    took = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (reset) took[i] = 1'b0;
        else if (took[i]) begin
          if (src_q[i].size() > 0) void'(src_q[i].pop_front());
          took[i] = 1'b0;
        end
        if (!reset && bus.req_ready[i]) took[i] = 1'b1;
        bus.req_valid[i] = src_q[i].size() > 0;
        bus.req_last[i] = (src_q[i].size() > 0) ? src_q[i][0][8] : 1'b0;
        bus.req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0][7:0] : 8'h00;
      end
    end
  end
  // transmitter model: tx_done pulse done_delay cycles after tx_start
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (!bus.busy) cd = 0;
      else if (bus.tx_start && auto_done != 0) cd = done_delay;
      else if (cd > 0) begin
        cd--;
        if (cd == 0) bus.tx_done = 1'b1;
      end
    end
  end
  // frame monitor
  initial forever begin
    @(negedge clk);
    if (!reset && bus.tx_start) obs_q.push_back({bus.grant_id, bus.tx_data});
  end
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      tick();
      ok = bus.tx_start;
    end
  endtask
  task automatic wait_obs(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      if (obs_q.size() > 0) ok = 1'b1;
      else tick();
    end
  endtask
  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      if (!bus.busy) ok = 1'b1;
      else tick();
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) src_q[i].delete();
    sb_q.delete();
    obs_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.busy, bus.tx_start, bus.req_ready, bus.tx_data, bus.baud_sel, bus.grant_id, bus.timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b start=%b ready=%b data=%h baud=%b grant=%0d err=%b exp all 0",
               bus.busy, bus.tx_start, bus.req_ready, bus.tx_data, bus.baud_sel, bus.grant_id, bus.timeout_err);
    end
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.req_ready !== '0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b ready=%b exp 0/0", bus.busy, bus.req_ready);
    end
  endtask
  task automatic test_single();
    logic [IW+7:0] got, exp;
    bit ok;
    auto_done = 1;
    done_delay = 20;
    src_q[2].push_back({1'b1, 8'hA5});
    sb_q.push_back({2'd2, 8'hA5});
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got busy=%b exp 0", bus.busy);
    end
    tick();
    checks++;
    if (bus.req_ready !== 4'b0100 || bus.grant_id !== 2'd2) begin
      failures++;
      $display("FAIL single_ready got ready=%b grant=%0d exp 0100/2", bus.req_ready, bus.grant_id);
    end
    tick();
    checks++;
    if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'hA5 || bus.req_ready !== '0) begin
      failures++;
      $display("FAIL single_start got start=%b data=%h ready=%b exp 1/a5/0000", bus.tx_start, bus.tx_data, bus.req_ready);
    end
    tick();
    checks++;
    if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL single_pulse got start=%b data=%h exp 0/a5", bus.tx_start, bus.tx_data);
    end
    wait_obs(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_frame got no frame exp id=2 data=a5");
    end else begin
      got = obs_q.pop_front();
      exp = sb_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL single_frame got %h exp %h", got, exp);
      end
    end
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_idle_end got busy=%b exp 0", bus.busy);
    end
  endtask
  task automatic test_round_robin();
    logic [IW+7:0] got, exp;
    bit ok;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      src_q[i].push_back({1'b1, 8'(8'h10 * i)});
      sb_q.push_back({IW'(i), 8'(8'h10 * i)});
    end
    src_q[0].push_back({1'b1, 8'h01});
    sb_q.push_back({2'd0, 8'h01});
    for (int k = 0; k < 5; k++) begin
      wait_obs(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rr_frame%0d got no frame exp %h", k, sb_q[0]);
      end else begin
        got = obs_q.pop_front();
        exp = sb_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL rr_frame%0d got id=%0d data=%h exp id=%0d data=%h", k, got[IW+7:8], got[7:0], exp[IW+7:8], exp[7:0]);
        end
      end
    end
    wait_idle(ok);
  endtask
  task automatic test_lock();
    logic [IW+7:0] got, exp;
    bit ok;
    do_reset();
    src_q[0].push_back({1'b0, 8'h01});
    src_q[0].push_back({1'b0, 8'h02});
    src_q[0].push_back({1'b1, 8'h03});
    src_q[1].push_back({1'b1, 8'hB1});
    sb_q.push_back({2'd0, 8'h01});
    sb_q.push_back({2'd0, 8'h02});
    sb_q.push_back({2'd0, 8'h03});
    sb_q.push_back({2'd1, 8'hB1});
    for (int k = 0; k < 4; k++) begin
      wait_obs(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL lock_frame%0d got no frame exp %h", k, sb_q[0]);
      end else begin
        got = obs_q.pop_front();
        exp = sb_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL lock_frame%0d got id=%0d data=%h exp id=%0d data=%h", k, got[IW+7:8], got[7:0], exp[IW+7:8], exp[7:0]);
        end
      end
    end
    wait_idle(ok);
  endtask
  task automatic test_config();
    logic [IW+7:0] got, exp;
    bit ok, changed;
    do_reset();
    bus.cfg_baud_sel = 2'b01;
    bus.cfg_wr = 1'b1;
    tick();
    bus.cfg_wr = 1'b0;
    checks++;
    if (bus.baud_sel !== 2'b01) begin
      failures++;
      $display("FAIL cfg_idle got %b exp 01", bus.baud_sel);
    end
    src_q[1].push_back({1'b1, 8'h5A});
    sb_q.push_back({2'd1, 8'h5A});
    wait_start(ok);
    tick();
    bus.cfg_baud_sel = 2'b11;
    bus.cfg_wr = 1'b1;
    tick();
    bus.cfg_wr = 1'b0;
    changed = 1'b0;
    for (int n = 0; n < 200 && bus.busy; n++) begin
      if (bus.baud_sel !== 2'b01) changed = 1'b1;
      tick();
    end
    checks++;
    if (changed || bus.busy !== 1'b0 || bus.baud_sel !== 2'b01) begin
      failures++;
      $display("FAIL cfg_held got changed=%b busy=%b baud=%b exp 0/0/01", changed, bus.busy, bus.baud_sel);
    end
    tick();
    checks++;
    if (bus.baud_sel !== 2'b11) begin
      failures++;
      $display("FAIL cfg_pending got %b exp 11", bus.baud_sel);
    end
    wait_obs(ok);
    checks++;
    if (!ok || obs_q[0] !== sb_q[0]) begin
      failures++;
      $display("FAIL cfg_frame got ok=%b frame=%h exp %h", ok, ok ? obs_q[0] : '0, sb_q[0]);
    end
    obs_q.delete();
    sb_q.delete();
    src_q[0].push_back({1'b1, 8'hC3});
    tick();
    bus.cfg_baud_sel = 2'b10;
    bus.cfg_wr = 1'b1;
    tick();
    bus.cfg_wr = 1'b0;
    checks++;
    if (bus.baud_sel !== 2'b10 || bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL cfg_simul got baud=%b ready=%b exp 10/0001", bus.baud_sel, bus.req_ready);
    end
    wait_idle(ok);
    obs_q.delete();
  endtask
  task automatic test_timeout();
    logic [IW+7:0] got, exp;
    bit ok;
    int n;
    do_reset();
    auto_done = 0;
    src_q[1].push_back({1'b1, 8'h11});
    src_q[2].push_back({1'b1, 8'h22});
    sb_q.push_back({2'd1, 8'h11});
    sb_q.push_back({2'd2, 8'h22});
    wait_start(ok);
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != TMO + 1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_cycles got %0d cycles busy=%b exp %0d cycles busy=0", n, bus.busy, TMO + 1);
    end
    auto_done = 1;
    for (int k = 0; k < 2; k++) begin
      wait_obs(ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL tmo_frame%0d got no frame exp %h", k, sb_q[0]);
      end else begin
        got = obs_q.pop_front();
        exp = sb_q.pop_front();
        if (got !== exp) begin
          failures++;
          $display("FAIL tmo_frame%0d got %h exp %h", k, got, exp);
        end
      end
    end
    wait_idle(ok);
    checks++;
    if (bus.timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_sticky got %b exp 1", bus.timeout_err);
    end
    bus.err_clr = 1'b1;
    tick();
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear got %b exp 0", bus.timeout_err);
    end
    auto_done = 0;
    src_q[3].push_back({1'b1, 8'h33});
    wait_start(ok);
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n != TMO + 1) begin
      failures++;
      $display("FAIL tmo_set_wins got %0d cycles exp %0d", n, TMO + 1);
    end
    tick();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL tmo_clear_after got %b exp 0", bus.timeout_err);
    end
    auto_done = 1;
    obs_q.delete();
  endtask
  task automatic test_reset_mid_wait();
    bit ok;
    do_reset();
    src_q[3].push_back({1'b0, 8'h3C});
    src_q[3].push_back({1'b1, 8'h3D});
    wait_start(ok);
    tick();
    tick();
    checks++;
    if (dut.lock !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre got lock=%b busy=%b exp 1/1", dut.lock, bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0 || bus.req_ready !== '0 || dut.lock !== 1'b0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL rst_async got busy=%b start=%b ready=%b lock=%b exp all 0", bus.busy, bus.tx_start, bus.req_ready, dut.lock);
    end
    for (int i = 0; i < NR; i++) src_q[i].delete();
    sb_q.delete();
    obs_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_single();
  endtask
  initial begin
    bus.cfg_wr = 1'b0;
    bus.cfg_baud_sel = 2'b00;
    bus.err_clr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_config();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
